// File: rtl/axi_core_bridge_pkg.sv
// Shared constants for the AXI-to-core-bus bridge: AXI burst/response codes
// and the bridge FSM state encoding.
package axi_core_bridge_pkg;

  typedef logic [1:0] axi_burst_t;
  typedef logic [1:0] axi_resp_t;
  typedef logic [2:0] state_t;

  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_DATA = 3'd1;
  localparam state_t ST_WR_BUS  = 3'd2;
  localparam state_t ST_WR_RESP = 3'd3;
  localparam state_t ST_RD_BUS  = 3'd4;
  localparam state_t ST_RD_RESP = 3'd5;

endpackage

// File: rtl/axi_core_bridge.sv
// AXI4 slave that turns read/write bursts into single-word core-bus accesses,
// one transaction at a time, echoing AXI IDs and mapping bus responses to RRESP/BRESP.
module axi_core_bridge
  import axi_core_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     slv_axi_awid,
  input  logic [ADDR_W-1:0]   slv_axi_awaddr,
  input  logic [7:0]          slv_axi_awlen,
  input  logic [2:0]          slv_axi_awsize,
  input  logic [1:0]          slv_axi_awburst,
  input  logic                slv_axi_awvalid,
  output logic                slv_axi_awready,
  input  logic [DATA_W-1:0]   slv_axi_wdata,
  input  logic [DATA_W/8-1:0] slv_axi_wstrb,
  input  logic                slv_axi_wlast,
  input  logic                slv_axi_wvalid,
  output logic                slv_axi_wready,
  output logic [ID_W-1:0]     slv_axi_bid,
  output logic [1:0]          slv_axi_bresp,
  output logic                slv_axi_bvalid,
  input  logic                slv_axi_bready,
  input  logic [ID_W-1:0]     slv_axi_arid,
  input  logic [ADDR_W-1:0]   slv_axi_araddr,
  input  logic [7:0]          slv_axi_arlen,
  input  logic [2:0]          slv_axi_arsize,
  input  logic [1:0]          slv_axi_arburst,
  input  logic                slv_axi_arvalid,
  output logic                slv_axi_arready,
  output logic [ID_W-1:0]     slv_axi_rid,
  output logic [DATA_W-1:0]   slv_axi_rdata,
  output logic [1:0]          slv_axi_rresp,
  output logic                slv_axi_rlast,
  output logic                slv_axi_rvalid,
  input  logic                slv_axi_rready,
  output logic [ADDR_W-1:0]   mst_bus_addr,
  output logic                mst_bus_read,
  output logic                mst_bus_write,
  output logic [DATA_W-1:0]   mst_bus_writedata,
  output logic [DATA_W/8-1:0] mst_bus_byteenable,
  input  logic [DATA_W-1:0]   mst_bus_readdata,
  input  logic [1:0]          mst_bus_response,
  input  logic                mst_bus_waitrequest
);

  localparam int          STRB_W  = DATA_W / 8;
  localparam logic [2:0]  SIZE_OK = 3'($clog2(STRB_W));
  localparam logic [11:0] STEP    = 12'(STRB_W);

  state_t              state;
  logic                prio_rd;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [1:0]          burst_q;
  logic                bad_q;
  logic [1:0]          err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                wlast_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic                grant_wr;
  logic                grant_rd;
  logic                last_beat;
  logic                bad_aw;
  logic                bad_ar;
  logic                bus_done;
  logic [ADDR_W-1:0]   next_addr;
  logic [1:0]          merged_err;

  // Round-robin only matters under contention; prio_rd means read wins the next tie.
  assign grant_wr  = (state == ST_IDLE) && slv_axi_awvalid && (!slv_axi_arvalid || !prio_rd);
  assign grant_rd  = (state == ST_IDLE) && slv_axi_arvalid && !grant_wr;
  assign last_beat = (cnt_q == len_q);
  assign bad_aw    = ((slv_axi_awburst != AXI_BURST_FIXED) && (slv_axi_awburst != AXI_BURST_INCR))
                     || (slv_axi_awsize != SIZE_OK);
  assign bad_ar    = ((slv_axi_arburst != AXI_BURST_FIXED) && (slv_axi_arburst != AXI_BURST_INCR))
                     || (slv_axi_arsize != SIZE_OK);
  // Rejected bursts never touch the bus, so they complete immediately.
  assign bus_done  = bad_q || !mst_bus_waitrequest;
  assign next_addr = (burst_q == AXI_BURST_FIXED) ? addr_q
                     : {addr_q[ADDR_W-1:12], addr_q[11:0] + STEP};

  // First non-OKAY code sticks; a WLAST mismatch only reports if nothing else did.
  always_comb begin
    merged_err = err_q;
    if (merged_err == AXI_RESP_OKAY)
      merged_err = bad_q ? AXI_RESP_SLVERR : mst_bus_response;
    if ((merged_err == AXI_RESP_OKAY) && (wlast_q != last_beat))
      merged_err = AXI_RESP_SLVERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      prio_rd <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      if (grant_wr && slv_axi_arvalid)
        prio_rd <= 1'b1;
      else if (grant_rd && slv_axi_awvalid)
        prio_rd <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            id_q    <= slv_axi_awid;
            addr_q  <= slv_axi_awaddr;
            len_q   <= slv_axi_awlen;
            burst_q <= slv_axi_awburst;
            bad_q   <= bad_aw;
            cnt_q   <= '0;
            err_q   <= AXI_RESP_OKAY;
            state   <= ST_WR_DATA;
          end else if (grant_rd) begin
            id_q    <= slv_axi_arid;
            addr_q  <= slv_axi_araddr;
            len_q   <= slv_axi_arlen;
            burst_q <= slv_axi_arburst;
            bad_q   <= bad_ar;
            cnt_q   <= '0;
            err_q   <= AXI_RESP_OKAY;
            state   <= ST_RD_BUS;
          end
        end
        ST_WR_DATA: begin
          if (slv_axi_wvalid) begin
            wdata_q <= slv_axi_wdata;
            wstrb_q <= slv_axi_wstrb;
            wlast_q <= slv_axi_wlast;
            state   <= ST_WR_BUS;
          end
        end
        ST_WR_BUS: begin
          if (bus_done) begin
            err_q <= merged_err;
            if (last_beat || wlast_q) begin
              state <= ST_WR_RESP;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 8'd1;
              state  <= ST_WR_DATA;
            end
          end
        end
        ST_WR_RESP: begin
          if (slv_axi_bready)
            state <= ST_IDLE;
        end
        ST_RD_BUS: begin
          if (bus_done) begin
            rdata_q <= bad_q ? '0 : mst_bus_readdata;
            rresp_q <= bad_q ? AXI_RESP_SLVERR : mst_bus_response;
            state   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (slv_axi_rready) begin
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 8'd1;
              state  <= ST_RD_BUS;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign slv_axi_awready    = grant_wr;
  assign slv_axi_arready    = grant_rd;
  assign slv_axi_wready     = (state == ST_WR_DATA);
  assign slv_axi_bvalid     = (state == ST_WR_RESP);
  assign slv_axi_bid        = id_q;
  assign slv_axi_bresp      = err_q;
  assign slv_axi_rvalid     = (state == ST_RD_RESP);
  assign slv_axi_rid        = id_q;
  assign slv_axi_rdata      = rdata_q;
  assign slv_axi_rresp      = rresp_q;
  assign slv_axi_rlast      = (state == ST_RD_RESP) && last_beat;
  assign mst_bus_addr       = addr_q;
  assign mst_bus_write      = (state == ST_WR_BUS) && !bad_q;
  assign mst_bus_read       = (state == ST_RD_BUS) && !bad_q;
  assign mst_bus_writedata  = wdata_q;
  assign mst_bus_byteenable = wstrb_q;

endmodule

// File: tb/tb_axi_core_bridge.sv
// Scoreboard bench for axi_core_bridge: a transaction-level model predicts bus
// accesses and B/R responses; a negedge monitor compares whatever the DUT presents.
module tb_axi_core_bridge;
  import axi_core_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata;
  logic [1:0]  bus_response;
  logic        bus_waitrequest = 1'b0;

  always #5 clk = ~clk;

  axi_core_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .slv_axi_awid(awid), .slv_axi_awaddr(awaddr), .slv_axi_awlen(awlen),
    .slv_axi_awsize(awsize), .slv_axi_awburst(awburst),
    .slv_axi_awvalid(awvalid), .slv_axi_awready(awready),
    .slv_axi_wdata(wdata), .slv_axi_wstrb(wstrb), .slv_axi_wlast(wlast),
    .slv_axi_wvalid(wvalid), .slv_axi_wready(wready),
    .slv_axi_bid(bid), .slv_axi_bresp(bresp), .slv_axi_bvalid(bvalid), .slv_axi_bready(bready),
    .slv_axi_arid(arid), .slv_axi_araddr(araddr), .slv_axi_arlen(arlen),
    .slv_axi_arsize(arsize), .slv_axi_arburst(arburst),
    .slv_axi_arvalid(arvalid), .slv_axi_arready(arready),
    .slv_axi_rid(rid), .slv_axi_rdata(rdata), .slv_axi_rresp(rresp), .slv_axi_rlast(rlast),
    .slv_axi_rvalid(rvalid), .slv_axi_rready(rready),
    .mst_bus_addr(bus_addr), .mst_bus_read(bus_read), .mst_bus_write(bus_write),
    .mst_bus_writedata(bus_writedata), .mst_bus_byteenable(bus_byteenable),
    .mst_bus_readdata(bus_readdata), .mst_bus_response(bus_response),
    .mst_bus_waitrequest(bus_waitrequest)
  );

  typedef struct { logic is_write; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } bus_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_beat_t;

  bus_exp_t bus_q[$];
  r_exp_t   r_q[$];
  b_exp_t   b_q[$];
  w_beat_t  w_beats[$];

  int tests_run = 0;
  int tests_failed = 0;
  int wait_cfg = -1;
  int rdelay_fixed = -1;
  bit prio_rd_model = 1'b0;
  int stall_left = 0;
  bit in_req = 1'b0;

  // Core-bus slave: contents and error map are pure functions of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [1:0] slave_resp(input logic [31:0] a);
    case (a[11:8])
      4'h5:    return AXI_RESP_SLVERR;
      4'h6:    return AXI_RESP_DECERR;
      default: return AXI_RESP_OKAY;
    endcase
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst, input int i);
    if (burst == AXI_BURST_FIXED) return start;
    return (start & 32'hFFFF_F000) | ((start + 32'(4 * i)) & 32'h0000_0FFF);
  endfunction

  function automatic bit is_bad(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR)) || (size != 3'd2);
  endfunction

  assign bus_readdata = mem_word(bus_addr);
  assign bus_response = slave_resp(bus_addr);

  always @(posedge clk) begin
    #2;
    if (bus_read || bus_write) begin
      if (!in_req) begin
        in_req = 1'b1;
        stall_left = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 2));
      end else if (stall_left > 0) begin
        stall_left--;
      end
    end else begin
      in_req = 1'b0;
    end
    bus_waitrequest = in_req && (stall_left > 0);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNote(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got no matching event, expected one (t=%0t)", name, $time);
  endtask

  // Monitor: every presented output is checked against the head of its queue each cycle,
  // which also proves the fields hold steady until the handshake pops the entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_read || bus_write) begin
        checkOutput("bus_rw_both_high", 64'(bus_read && bus_write), 64'd0);
        if (bus_q.size() == 0) begin
          failNote("bus_unexpected_access");
        end else begin
          checkOutput("bus_is_write", 64'(bus_write), 64'(bus_q[0].is_write));
          checkOutput("bus_addr", 64'(bus_addr), 64'(bus_q[0].addr));
          if (bus_q[0].is_write) begin
            checkOutput("bus_writedata", 64'(bus_writedata), 64'(bus_q[0].data));
            checkOutput("bus_byteenable", 64'(bus_byteenable), 64'(bus_q[0].be));
          end
          if (!bus_waitrequest) void'(bus_q.pop_front());
        end
      end
      if (bvalid) begin
        if (b_q.size() == 0) begin
          failNote("b_unexpected");
        end else begin
          checkOutput("bid", 64'(bid), 64'(b_q[0].id));
          checkOutput("bresp", 64'(bresp), 64'(b_q[0].resp));
          if (bready) void'(b_q.pop_front());
        end
      end
      if (rvalid) begin
        if (r_q.size() == 0) begin
          failNote("r_unexpected");
        end else begin
          checkOutput("rid", 64'(rid), 64'(r_q[0].id));
          checkOutput("rdata", 64'(rdata), 64'(r_q[0].data));
          checkOutput("rresp", 64'(rresp), 64'(r_q[0].resp));
          checkOutput("rlast", 64'(rlast), 64'(r_q[0].last));
          if (rready) void'(r_q.pop_front());
        end
      end
    end
  end

  // The master sends n_send beats; the burst ends at beat len or at the first WLAST.
  task automatic predictWrite(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int n_send, input bit last_flag, input bit fixed_data);
    bit bad;
    logic [1:0] err;
    bad = is_bad(burst, size);
    err = AXI_RESP_OKAY;
    for (int i = 0; i < n_send; i++) begin
      w_beat_t b;
      b.data = fixed_data ? 32'hDEAD_BEEF : $urandom;
      b.strb = fixed_data ? 4'hF : 4'($urandom_range(1, 15));
      b.last = last_flag && (i == n_send - 1);
      w_beats.push_back(b);
      if (!bad) bus_q.push_back('{1'b1, beat_addr(addr, burst, i), b.data, b.strb});
      if (err == AXI_RESP_OKAY) err = bad ? AXI_RESP_SLVERR : slave_resp(beat_addr(addr, burst, i));
    end
    if ((err == AXI_RESP_OKAY) && !(last_flag && (n_send - 1 == int'(len)))) err = AXI_RESP_SLVERR;
    b_q.push_back('{id, err});
  endtask

  task automatic predictRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit bad;
    bad = is_bad(burst, size);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      a = beat_addr(addr, burst, i);
      if (bad) begin
        r_q.push_back('{id, 32'd0, AXI_RESP_SLVERR, i == int'(len)});
      end else begin
        bus_q.push_back('{1'b0, a, 32'd0, 4'd0});
        r_q.push_back('{id, mem_word(a), slave_resp(a), i == int'(len)});
      end
    end
  endtask

  task automatic driveAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    do begin @(negedge clk); k++; end while (!awready && k < 3000);
    if (!awready) failNote("aw_handshake_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic driveAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    do begin @(negedge clk); k++; end while (!arready && k < 3000);
    if (!arready) failNote("ar_handshake_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic driveW(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      int gap;
      wdata = w_beats[0].data; wstrb = w_beats[0].strb; wlast = w_beats[0].last; wvalid = 1'b1;
      do begin @(negedge clk); k++; end while (!wready && k < 3000);
      if (!wready) failNote("w_handshake_timeout");
      @(posedge clk); #1;
      wvalid = 1'b0;
      void'(w_beats.pop_front());
      gap = $urandom_range(0, 1);
      for (int j = 0; j < gap; j++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic awaitB();
    int k = 0;
    int d;
    do begin @(negedge clk); k++; end while (!bvalid && k < 3000);
    if (!bvalid) begin failNote("b_timeout"); @(posedge clk); #1; return; end
    d = $urandom_range(0, 2);
    for (int j = 0; j < d; j++) begin @(posedge clk); #1; end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic awaitR(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      int d;
      do begin @(negedge clk); k++; end while (!rvalid && k < 3000);
      if (!rvalid) begin failNote("r_timeout"); @(posedge clk); #1; return; end
      d = (rdelay_fixed >= 0) ? rdelay_fixed : int'($urandom_range(0, 2));
      for (int j = 0; j < d; j++) begin @(posedge clk); #1; end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit is_write, input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                               input int n_send, input bit last_flag, input bit fixed_data);
    if (is_write) begin
      predictWrite(id, addr, len, size, burst, n_send, last_flag, fixed_data);
      driveAw(id, addr, len, size, burst);
      driveW(n_send);
      awaitB();
    end else begin
      predictRead(id, addr, len, size, burst);
      driveAr(id, addr, len, size, burst);
      awaitR(int'(len) + 1);
    end
  endtask

  task automatic applyContention(input logic [3:0] wid, input logic [31:0] waddr,
                                 input logic [3:0] rid_in, input logic [31:0] raddr);
    bit write_first;
    write_first = !prio_rd_model;
    prio_rd_model = !prio_rd_model;
    if (write_first) begin
      predictWrite(wid, waddr, 8'd1, 3'd2, AXI_BURST_INCR, 2, 1'b1, 1'b0);
      predictRead(rid_in, raddr, 8'd1, 3'd2, AXI_BURST_INCR);
    end else begin
      predictRead(rid_in, raddr, 8'd1, 3'd2, AXI_BURST_INCR);
      predictWrite(wid, waddr, 8'd1, 3'd2, AXI_BURST_INCR, 2, 1'b1, 1'b0);
    end
    fork
      begin driveAw(wid, waddr, 8'd1, 3'd2, AXI_BURST_INCR); driveW(2); awaitB(); end
      begin driveAr(rid_in, raddr, 8'd1, 3'd2, AXI_BURST_INCR); awaitR(2); end
    join
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected the bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_write", 64'(bus_write), 64'd0);
    checkOutput("reset_read", 64'(bus_read), 64'd0);
    checkOutput("reset_wready", 64'(wready), 64'd0);
    checkOutput("reset_bvalid", 64'(bvalid), 64'd0);
    checkOutput("reset_rvalid", 64'(rvalid), 64'd0);
    checkOutput("reset_addr", 64'(bus_addr), 64'd0);
    checkOutput("reset_rdata", 64'(rdata), 64'd0);
    checkOutput("reset_be", 64'(bus_byteenable), 64'd0);
    @(posedge clk); #1;

    wait_cfg = 2;
    applyStimulus(1'b1, 4'h5, 32'h0000_0100, 8'd0, 3'd2, AXI_BURST_INCR, 1, 1'b1, 1'b1);
    wait_cfg = -1;

    rdelay_fixed = 3;
    applyStimulus(1'b0, 4'hA, 32'h0000_0200, 8'd3, 3'd2, AXI_BURST_INCR, 0, 1'b0, 1'b0);
    rdelay_fixed = -1;

    applyContention(4'h1, 32'h0000_1000, 4'h2, 32'h0000_2000);
    applyContention(4'h3, 32'h0000_3010, 4'h4, 32'h0000_4020);

    applyStimulus(1'b1, 4'h7, 32'h0000_04FC, 8'd3, 3'd2, AXI_BURST_INCR, 4, 1'b1, 1'b0);

    applyStimulus(1'b1, 4'h8, 32'h0000_0300, 8'd2, 3'd2, AXI_BURST_FIXED, 3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h9, 32'h0000_0300, 8'd2, 3'd2, AXI_BURST_FIXED, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'hB, 32'h0000_0FFC, 8'd1, 3'd2, AXI_BURST_INCR, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hC, 32'h0001_0FFC, 8'd1, 3'd2, AXI_BURST_INCR, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hD, 32'h0000_0400, 8'd1, 3'd2, AXI_BURST_WRAP, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'hE, 32'h0000_0400, 8'd2, 3'd2, AXI_BURST_WRAP, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'hF, 32'h0000_0800, 8'd0, 3'd1, AXI_BURST_INCR, 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'h2, 32'h0000_0A00, 8'd3, 3'd2, AXI_BURST_INCR, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h3, 32'h0000_0B00, 8'd1, 3'd2, AXI_BURST_INCR, 2, 1'b0, 1'b0);

    applyStimulus(1'b0, 4'h6, 32'h0000_0E00, 8'd255, 3'd2, AXI_BURST_INCR, 0, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      bit w;
      int r;
      logic [1:0] br;
      logic [2:0] sz;
      logic [7:0] ln;
      w  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      br = (r < 4) ? AXI_BURST_FIXED : ((r < 9) ? AXI_BURST_INCR : AXI_BURST_WRAP);
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'd2;
      ln = 8'($urandom_range(0, 7));
      applyStimulus(w, 4'($urandom), $urandom & 32'hFFFF_FFFC, ln, sz, br, int'(ln) + 1, 1'b1, 1'b0);
    end

    wait_cfg = 6;
    predictWrite(4'h9, 32'h0000_0700, 8'd0, 3'd2, AXI_BURST_INCR, 1, 1'b1, 1'b0);
    driveAw(4'h9, 32'h0000_0700, 8'd0, 3'd2, AXI_BURST_INCR);
    driveW(1);
    begin
      int k = 0;
      while (!bus_write && k < 50) begin @(negedge clk); k++; end
      if (!bus_write) failNote("reset_test_write_start");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus_q.delete();
    b_q.delete();
    w_beats.delete();
    prio_rd_model = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cfg = -1;
    @(negedge clk);
    checkOutput("abort_write", 64'(bus_write), 64'd0);
    checkOutput("abort_read", 64'(bus_read), 64'd0);
    checkOutput("abort_awready", 64'(awready), 64'd0);
    checkOutput("abort_wready", 64'(wready), 64'd0);
    checkOutput("abort_arready", 64'(arready), 64'd0);
    checkOutput("abort_bvalid", 64'(bvalid), 64'd0);
    checkOutput("abort_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'h4, 32'h0000_0120, 8'd1, 3'd2, AXI_BURST_INCR, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h5, 32'h0000_0120, 8'd1, 3'd2, AXI_BURST_INCR, 0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    checkOutput("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    checkOutput("b_queue_drained", 64'(b_q.size()), 64'd0);
    checkOutput("r_queue_drained", 64'(r_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
